snake_head_ctrl: RTL and testbench
==================================

Name: snake_head_ctrl

Overview:
Parametrised snake-head controller, the next generation of the snake head mover. It latches and filters player direction requests and rejects 180-degree reversals. The head advances at a programmable rate derived from a game-tick strobe, and the arena edge can either wrap or kill. It sits between the per-player input decoder and the snake body/collision logic, one instance per player.

Parameters:
COORD_W, 7, coordinate width in bits; WIDTH and HEIGHT must be <= 2^COORD_W - 1 so the all-ones coordinate lies off-arena
WIDTH, 32, arena columns; valid x is 0..WIDTH-1
HEIGHT, 32, arena rows; valid y is 0..HEIGHT-1
STARTX, 3, x after reset/restart
STARTY, 3, y after reset/restart
START_DIR, 1, direction after reset/restart (0 up, 1 right, 2 down, 3 left)
WRAP, 1, 1 = wrap at edges; 0 = leaving the arena kills the head
STEP_DIV, 4, number of step_en pulses per head move (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
up  in  1  direction request, level
right  in  1  direction request, level
down  in  1  direction request, level
left  in  1  direction request, level
step_en  in  1  game-tick strobe, one cycle wide
dead  in  1  external kill (body/other-player collision)
restart  in  1  synchronous return to IDLE
x  out  COORD_W  head column
y  out  COORD_W  head row
dir  out  2  committed direction (0 up, 1 right, 2 down, 3 left)
alive  out  1  high in IDLE and RUN
moved  out  1  one-cycle pulse, coincident with each x/y update from a move
hit_wall  out  1  sticky; death was caused by the arena edge

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, x=STARTX, y=STARTY, dir=START_DIR, pending=none, step counter=0, alive=1, moved=0, hit_wall=0.
- Request decode: valid only when exactly one of up/right/down/left is high. Zero or multiple inputs high means no request that cycle.
- States: IDLE, RUN, DEAD. All transitions occur on the clk edge.
- IDLE: coordinates are held and step_en is ignored. Any valid request, including the opposite of START_DIR, sets dir and moves to RUN. The counter clears and no move occurs on that edge.
- RUN, request handling: a request equal to the reverse of the committed dir is dropped. Any other request overwrites pending, so the last accepted request wins.
- RUN, step counting: the counter increments on each step_en. When counter==STEP_DIV-1 and step_en is high, the counter clears and a move occurs.
- RUN, move: effective direction is the request from this same cycle if it is valid and not a reversal; otherwise pending if set; otherwise dir. On the move edge, dir <= effective direction, pending clears, x/y update by +/-1 along one axis, and moved=1 on the following cycle, aligned with the new x/y.
- Edge, WRAP=1: the coordinate wraps 0 <-> WIDTH-1 / HEIGHT-1.
- Edge, WRAP=0: a move that would leave the arena goes to DEAD with hit_wall=1 and moved=0.
- DEAD: x=y=all ones (2^COORD_W-1) and alive=0. Inputs are ignored except restart. The state is absorbing until restart or reset.
- dead input: from IDLE or RUN, goes to DEAD on the next edge with hit_wall=0. It has priority over a simultaneous move, so no moved pulse is produced.
- restart: from any state, returns to the reset values on the next edge, including hit_wall=0. restart has priority over dead and over a move.
- Reset mid-operation: outputs go to reset values immediately, with no dependence on clk.
- Arithmetic: all coordinate math is done in COORD_W bits. Boundary compares use WIDTH-1 and HEIGHT-1 truncated to COORD_W bits. Counter width is max(1, clog2(STEP_DIV)).

Test Plan:
(Parameters: WIDTH=HEIGHT=16, STARTX=STARTY=3, START_DIR=1, STEP_DIV=2, COORD_W=7 unless noted.)
1. Reset, then right for 1 cycle, then step_en held high -> state RUN; x=4 after the 2nd step_en and x=5 after the 4th; moved pulses every 2 cycles; y stays 3.
2. RUN moving right; pulse left -> ignored, x keeps incrementing. Then pulse up followed by left before the next move -> pending=up; next move y=2, dir=0.
3. WRAP=1, head at x=15 moving right, move -> x=0, alive=1, moved=1.
4. WRAP=0, head at x=15 moving right, move -> x=y=127, alive=0, hit_wall=1, no moved pulse.
5. dead asserted in the same cycle as a move -> x=y=127, hit_wall=0, moved=0. Then restart -> x=3, y=3, dir=1, IDLE; step_en ignored until a direction request.
6. Drop reset between clk edges while in RUN at x=9 -> x=3, y=3, dir=1, alive=1 before the next clk edge. Also check that up+left pressed together produces no request.

Source files
------------

// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: per-player snake head mover with direction filtering, rate division and edge handling.
// Ports:
//   clk, reset (async, active low)
//   up/right/down/left : level direction requests, valid only when exactly one is high
//   step_en            : game-tick strobe; STEP_DIV strobes make one head move
//   dead               : external kill, restart : synchronous return to IDLE
//   x, y, dir          : head position and committed direction (0 up, 1 right, 2 down, 3 left)
//   alive, moved       : alive in IDLE/RUN; moved pulses with each position update
//   hit_wall           : sticky, death came from leaving the arena
module snake_head_ctrl #(
   parameter int COORD_W   = 7,
   parameter int WIDTH     = 32,
   parameter int HEIGHT    = 32,
   parameter int STARTX    = 3,
   parameter int STARTY    = 3,
   parameter int START_DIR = 1,
   parameter int WRAP      = 1,
   parameter int STEP_DIV  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               up,
   input  logic               right,
   input  logic               down,
   input  logic               left,
   input  logic               step_en,
   input  logic               dead,
   input  logic               restart,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [1:0]         dir,
   output logic               alive,
   output logic               moved,
   output logic               hit_wall
);
   localparam int CNT_W = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);
   localparam logic [COORD_W-1:0] X0    = COORD_W'(STARTX);
   localparam logic [COORD_W-1:0] Y0    = COORD_W'(STARTY);
   localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
   localparam logic [1:0]         DIR0  = 2'(START_DIR);
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(STEP_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

   state_t             state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d, nx, ny;
   logic [1:0]         dir_q, dir_d, pend_q, pend_d, req, eff;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pend_v_q, pend_v_d, alive_q, alive_d, moved_q, moved_d, hit_q, hit_d;
   logic               req_v, req_ok, step_move, off_edge;

   always_comb begin
      req_v     = $onehot({left, down, right, up});
      req       = right ? 2'd1 : down ? 2'd2 : left ? 2'd3 : 2'd0;
      // a reversal is the committed direction with its high bit flipped
      req_ok    = req_v && (req != (dir_q ^ 2'd2));
      eff       = req_ok ? req : pend_v_q ? pend_q : dir_q;
      step_move = step_en && (cnt_q == LAST);
      off_edge  = (eff == 2'd0 && y_q == '0) || (eff == 2'd1 && x_q == X_MAX) ||
                  (eff == 2'd2 && y_q == Y_MAX) || (eff == 2'd3 && x_q == '0);
      nx        = eff == 2'd1 ? (x_q == X_MAX ? '0 : x_q + ONE) :
                  eff == 2'd3 ? (x_q == '0 ? X_MAX : x_q - ONE) : x_q;
      ny        = eff == 2'd2 ? (y_q == Y_MAX ? '0 : y_q + ONE) :
                  eff == 2'd0 ? (y_q == '0 ? Y_MAX : y_q - ONE) : y_q;
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      dir_d     = dir_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      cnt_d     = cnt_q;
      alive_d   = alive_q;
      moved_d   = 1'b0;
      hit_d     = hit_q;
      if (restart) begin
         state_d  = IDLE;
         x_d      = X0;
         y_d      = Y0;
         dir_d    = DIR0;
         pend_v_d = 1'b0;
         cnt_d    = '0;
         alive_d  = 1'b1;
         hit_d    = 1'b0;
      end else if (state_q != DEAD && dead) begin
         state_d  = DEAD;
         x_d      = '1;
         y_d      = '1;
         pend_v_d = 1'b0;
         cnt_d    = '0;
         alive_d  = 1'b0;
         hit_d    = 1'b0;
      end else if (state_q == IDLE && req_v) begin
         state_d = RUN;
         dir_d   = req;
         cnt_d   = '0;
      end else if (state_q == RUN) begin
         pend_d   = req_ok ? req : pend_q;
         pend_v_d = pend_v_q || req_ok;
         cnt_d    = step_en ? (step_move ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
         if (step_move) begin
            pend_v_d = 1'b0;
            if (off_edge && WRAP == 0) begin
               state_d = DEAD;
               x_d     = '1;
               y_d     = '1;
               alive_d = 1'b0;
               hit_d   = 1'b1;
            end else begin
               x_d     = nx;
               y_d     = ny;
               dir_d   = eff;
               moved_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         x_q      <= X0;
         y_q      <= Y0;
         dir_q    <= DIR0;
         pend_q   <= 2'd0;
         pend_v_q <= 1'b0;
         cnt_q    <= '0;
         alive_q  <= 1'b1;
         moved_q  <= 1'b0;
         hit_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dir_q    <= dir_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         cnt_q    <= cnt_d;
         alive_q  <= alive_d;
         moved_q  <= moved_d;
         hit_q    <= hit_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign dir      = dir_q;
   assign alive    = alive_q;
   assign moved    = moved_q;
   assign hit_wall = hit_q;
endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb_snake_head_ctrl: directed scenarios plus randomized run against a behavioural model, wrap and no-wrap instances.
module tb_snake_head_ctrl;
   localparam int W = 16, H = 16, SD = 2;

   logic       clk, rst_n, up, right, down, left, step_en, dead, restart;
   logic [6:0] x_o[2], y_o[2];
   logic [1:0] dir_o[2];
   logic       alive_o[2], moved_o[2], hit_o[2];
   int         n_chk, n_pass;
   int         m_st[2], m_x[2], m_y[2], m_dir[2], m_pend[2], m_cnt[2], m_moved[2], m_hit[2];

   snake_head_ctrl #(.COORD_W(7), .WIDTH(W), .HEIGHT(H), .STARTX(3), .STARTY(3), .START_DIR(1),
                     .WRAP(1), .STEP_DIV(SD)) dut_w (
      .clk(clk), .reset(rst_n), .up(up), .right(right), .down(down), .left(left),
      .step_en(step_en), .dead(dead), .restart(restart), .x(x_o[0]), .y(y_o[0]),
      .dir(dir_o[0]), .alive(alive_o[0]), .moved(moved_o[0]), .hit_wall(hit_o[0]));

   snake_head_ctrl #(.COORD_W(7), .WIDTH(W), .HEIGHT(H), .STARTX(3), .STARTY(3), .START_DIR(1),
                     .WRAP(0), .STEP_DIV(SD)) dut_n (
      .clk(clk), .reset(rst_n), .up(up), .right(right), .down(down), .left(left),
      .step_en(step_en), .dead(dead), .restart(restart), .x(x_o[1]), .y(y_o[1]),
      .dir(dir_o[1]), .alive(alive_o[1]), .moved(moved_o[1]), .hit_wall(hit_o[1]));

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_x[i] = 3; m_y[i] = 3; m_dir[i] = 1;
         m_pend[i] = -1; m_cnt[i] = 0; m_moved[i] = 0; m_hit[i] = 0;
      end
   endtask

   // state codes: 0 idle, 1 running, 2 dead; instance 1 is the kill-at-edge arena
   task automatic model_step();
      int r, e, nx, ny;
      bit ok;
      r = ($countones({up, right, down, left}) == 1) ? (up ? 0 : right ? 1 : down ? 2 : 3) : -1;
      for (int i = 0; i < 2; i++) begin
         m_moved[i] = 0;
         if (restart) begin
            m_st[i] = 0; m_x[i] = 3; m_y[i] = 3; m_dir[i] = 1; m_pend[i] = -1; m_cnt[i] = 0; m_hit[i] = 0;
         end else if (m_st[i] == 2) begin
         end else if (dead) begin
            m_st[i] = 2; m_x[i] = 127; m_y[i] = 127; m_hit[i] = 0; m_pend[i] = -1; m_cnt[i] = 0;
         end else if (m_st[i] == 0) begin
            if (r >= 0) begin m_st[i] = 1; m_dir[i] = r; m_cnt[i] = 0; end
         end else begin
            ok = (r >= 0) && (r != (m_dir[i] + 2) % 4);
            if (step_en && m_cnt[i] + 1 == SD) begin
               e  = ok ? r : (m_pend[i] >= 0 ? m_pend[i] : m_dir[i]);
               nx = m_x[i] + (e == 1 ? 1 : e == 3 ? -1 : 0);
               ny = m_y[i] + (e == 2 ? 1 : e == 0 ? -1 : 0);
               m_cnt[i] = 0; m_pend[i] = -1;
               if (i == 1 && (nx < 0 || nx >= W || ny < 0 || ny >= H)) begin
                  m_st[i] = 2; m_x[i] = 127; m_y[i] = 127; m_hit[i] = 1;
               end else begin
                  m_x[i] = (nx + W) % W; m_y[i] = (ny + H) % H; m_dir[i] = e; m_moved[i] = 1;
               end
            end else begin
               if (step_en) m_cnt[i]++;
               if (ok) m_pend[i] = r;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      {up, right, down, left, step_en, dead, restart} = '0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      {up, right, down, left, step_en, dead, restart} = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (x_o[i] !== 7'd3) $display("FAIL reset_x[%0d] got %0d want 3", i, x_o[i]); else n_pass++;
         n_chk++; if (y_o[i] !== 7'd3) $display("FAIL reset_y[%0d] got %0d want 3", i, y_o[i]); else n_pass++;
         n_chk++; if (dir_o[i] !== 2'd1) $display("FAIL reset_dir[%0d] got %0d want 1", i, dir_o[i]); else n_pass++;
         n_chk++; if ({alive_o[i], moved_o[i], hit_o[i]} !== 3'b100)
            $display("FAIL reset_flags[%0d] got %b want 100", i, {alive_o[i], moved_o[i], hit_o[i]}); else n_pass++;
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_move_right();
      int ex[4] = '{3, 4, 4, 5};
      int em[4] = '{0, 1, 0, 1};
      do_reset();
      right = 1; tick(); right = 0; step_en = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_chk++; if (x_o[0] !== 7'(ex[k])) $display("FAIL move_x[%0d] got %0d want %0d", k, x_o[0], ex[k]); else n_pass++;
         n_chk++; if (moved_o[0] !== 1'(em[k])) $display("FAIL move_pulse[%0d] got %0d want %0d", k, moved_o[0], em[k]); else n_pass++;
         n_chk++; if (y_o[0] !== 7'd3) $display("FAIL move_y[%0d] got %0d want 3", k, y_o[0]); else n_pass++;
      end
   endtask

   task automatic test_reversal();
      left = 1; tick(); left = 0; tick();
      n_chk++; if (x_o[0] !== 7'd6) $display("FAIL rev_x got %0d want 6", x_o[0]); else n_pass++;
      n_chk++; if (dir_o[0] !== 2'd1) $display("FAIL rev_dir got %0d want 1", dir_o[0]); else n_pass++;
      up = 1; tick(); up = 0; left = 1; step_en = 0; tick();
      n_chk++; if (y_o[0] !== 7'd3 || dir_o[0] !== 2'd1)
         $display("FAIL pend_hold got y=%0d dir=%0d want y=3 dir=1", y_o[0], dir_o[0]); else n_pass++;
      left = 0; step_en = 1; tick();
      n_chk++; if (y_o[0] !== 7'd2 || x_o[0] !== 7'd6) $display("FAIL pend_move got x=%0d y=%0d want x=6 y=2", x_o[0], y_o[0]); else n_pass++;
      n_chk++; if (dir_o[0] !== 2'd0 || moved_o[0] !== 1'b1)
         $display("FAIL pend_dir got dir=%0d moved=%0d want dir=0 moved=1", dir_o[0], moved_o[0]); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      right = 1; tick(); right = 0; step_en = 1;
      for (int k = 0; k < 60 && x_o[0] !== 7'd15; k++) tick();
      n_chk++; if (x_o[0] !== 7'd15 || x_o[1] !== 7'd15)
         $display("FAIL edge_reach got x=%0d/%0d want 15/15", x_o[0], x_o[1]); else n_pass++;
      tick(); tick();
      n_chk++; if ({x_o[0], y_o[0]} !== {7'd0, 7'd3}) $display("FAIL wrap_xy got x=%0d y=%0d want x=0 y=3", x_o[0], y_o[0]); else n_pass++;
      n_chk++; if ({alive_o[0], moved_o[0], hit_o[0]} !== 3'b110)
         $display("FAIL wrap_flags got %b want 110", {alive_o[0], moved_o[0], hit_o[0]}); else n_pass++;
      n_chk++; if ({x_o[1], y_o[1]} !== {7'd127, 7'd127}) $display("FAIL wall_xy got x=%0d y=%0d want 127", x_o[1], y_o[1]); else n_pass++;
      n_chk++; if ({alive_o[1], moved_o[1], hit_o[1]} !== 3'b001)
         $display("FAIL wall_flags got %b want 001", {alive_o[1], moved_o[1], hit_o[1]}); else n_pass++;
      right = 1; tick(); right = 0;
      n_chk++; if ({alive_o[1], hit_o[1], x_o[1]} !== {2'b01, 7'd127})
         $display("FAIL wall_sticky got alive=%0d hit=%0d x=%0d want 0 1 127", alive_o[1], hit_o[1], x_o[1]); else n_pass++;
   endtask

   task automatic test_dead_restart();
      do_reset();
      right = 1; tick(); right = 0; step_en = 1; tick();
      dead = 1; tick(); dead = 0;
      for (int i = 0; i < 2; i++) begin
         n_chk++; if ({x_o[i], y_o[i]} !== {7'd127, 7'd127}) $display("FAIL kill_xy[%0d] got x=%0d y=%0d want 127", i, x_o[i], y_o[i]); else n_pass++;
         n_chk++; if ({alive_o[i], moved_o[i], hit_o[i]} !== 3'b000)
            $display("FAIL kill_flags[%0d] got %b want 000", i, {alive_o[i], moved_o[i], hit_o[i]}); else n_pass++;
      end
      right = 1; tick();
      n_chk++; if (alive_o[0] !== 1'b0 || x_o[0] !== 7'd127) $display("FAIL dead_absorb got alive=%0d x=%0d want 0 127", alive_o[0], x_o[0]); else n_pass++;
      right = 0; step_en = 0; restart = 1; tick(); restart = 0;
      n_chk++; if ({x_o[1], y_o[1], dir_o[1]} !== {7'd3, 7'd3, 2'd1})
         $display("FAIL restart_pos got x=%0d y=%0d dir=%0d want 3 3 1", x_o[1], y_o[1], dir_o[1]); else n_pass++;
      n_chk++; if ({alive_o[1], hit_o[1]} !== 2'b10) $display("FAIL restart_flags got %b want 10", {alive_o[1], hit_o[1]}); else n_pass++;
      step_en = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_chk++; if (x_o[0] !== 7'd3 || moved_o[0] !== 1'b0)
            $display("FAIL idle_hold[%0d] got x=%0d moved=%0d want 3 0", k, x_o[0], moved_o[0]); else n_pass++;
      end
      right = 1; tick(); right = 0; tick(); tick();
      n_chk++; if (x_o[0] !== 7'd4) $display("FAIL idle_start got %0d want 4", x_o[0]); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      right = 1; tick(); right = 0; step_en = 1;
      for (int k = 0; k < 40 && x_o[0] !== 7'd9; k++) tick();
      n_chk++; if (x_o[0] !== 7'd9) $display("FAIL areset_reach got %0d want 9", x_o[0]); else n_pass++;
      step_en = 0;
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if ({x_o[0], y_o[0], dir_o[0]} !== {7'd3, 7'd3, 2'd1})
         $display("FAIL areset_pos got x=%0d y=%0d dir=%0d want 3 3 1", x_o[0], y_o[0], dir_o[0]); else n_pass++;
      n_chk++; if ({alive_o[0], moved_o[0]} !== 2'b10) $display("FAIL areset_flags got %b want 10", {alive_o[0], moved_o[0]}); else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      up = 1; left = 1; step_en = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_chk++; if ({x_o[0], y_o[0], dir_o[0], moved_o[0]} !== {7'd3, 7'd3, 2'd1, 1'b0})
            $display("FAIL multi_req[%0d] got x=%0d y=%0d dir=%0d moved=%0d want 3 3 1 0", k, x_o[0], y_o[0], dir_o[0], moved_o[0]);
         else n_pass++;
      end
      up = 0; left = 0;
   endtask

   task automatic test_random();
      logic [3:0] d;
      do_reset();
      for (int k = 0; k < 800; k++) begin
         d = $urandom_range(0, 2) != 0 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         {up, right, down, left} = d;
         step_en = 1'($urandom_range(0, 1));
         dead    = $urandom_range(0, 79) == 0;
         restart = $urandom_range(0, 39) == 0;
         tick();
         for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({x_o[i], y_o[i]} !== {7'(m_x[i]), 7'(m_y[i])} || alive_o[i] !== (m_st[i] != 2) ||
                moved_o[i] !== 1'(m_moved[i]) || hit_o[i] !== 1'(m_hit[i]) ||
                (m_st[i] != 2 && dir_o[i] !== 2'(m_dir[i])))
               $display("FAIL rand[%0d][%0d] got x=%0d y=%0d dir=%0d a=%0d m=%0d h=%0d want x=%0d y=%0d dir=%0d a=%0d m=%0d h=%0d",
                        k, i, x_o[i], y_o[i], dir_o[i], alive_o[i], moved_o[i], hit_o[i],
                        m_x[i], m_y[i], m_dir[i], m_st[i] != 2, m_moved[i], m_hit[i]);
            else n_pass++;
         end
      end
      {up, right, down, left, step_en, dead, restart} = '0;
   endtask

   initial begin
      clk = 1'b0;
      n_chk = 0;
      n_pass = 0;
      test_reset();
      test_move_right();
      test_reversal();
      test_wrap();
      test_dead_restart();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
